// File: rtl/jt51_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt51_pkg
// Description : Shared constants for the phase-generator parameter scheduler.
//               Defines the write-select field codes, the slot and channel
//               counts, and the depth of the phase-reset delay pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package jt51_pkg;

  localparam int C_SLOTS  = 32;
  localparam int C_CHANS  = 8;
  localparam int C_PG_DLY = 2;

  // Codes 5..7 are unassigned and are silently ignored by the write port.
  typedef enum logic [2:0] {
    SEL_KC    = 3'd0,
    SEL_KF    = 3'd1,
    SEL_DTMUL = 3'd2,
    SEL_DT2   = 3'd3,
    SEL_KON   = 3'd4
  } wr_sel_e;

endpackage
`default_nettype wire

// File: rtl/jt51_pg_sched_dly.sv
`default_nettype none
// ============================================================================
// Module      : jt51_pg_sched_dly
// Description : Clock-enable gated N-stage single-bit delay line with a
//               synchronous clear. The line shifts only on cycles where
//               i_cen is high and holds its contents otherwise.
// Ports       : clk   - system clock
//               rst   - synchronous active-high clear
//               i_cen - shift enable
//               i_d   - serial input
//               o_q   - output of the last stage
// Revision    : 1.0 - initial release
// ============================================================================
module jt51_pg_sched_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cen,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sh;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sh <= '0;
        end else if (i_cen) begin
          r_sh <= i_d;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sh <= '0;
        end else if (i_cen) begin
          r_sh <= {r_sh[DEPTH-2:0], i_d};
        end
      end
    end
  endgenerate

  assign o_q = r_sh[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/jt51_pg_sched.sv
`default_nettype none
// ============================================================================
// Module      : jt51_pg_sched
// Description : Slot scheduler for the phase generator. A 5-bit slot counter
//               walks all 32 operator slots; for each slot the channel
//               frequency (kc/kf) and operator parameters (mul/dt1/dt2) are
//               presented on registered outputs, and a key-on rising edge
//               raises a one-cen-cycle phase reset aligned to pipeline
//               stage III (two cen cycles after the parameters).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               cen           - clock enable for the slot sequence
//               wr_en/wr_sel/wr_slot/wr_data - parameter write port
//               slot, zero    - presented slot, high while slot == 0
//               kc, kf        - channel frequency of slot[2:0]
//               mul, dt1, dt2 - operator parameters of slot
//               pg_rst_III    - phase reset at stage III
//               mask          - per-slot mask (only with the option below)
// Options     : JT51_PG_SCHED_MASK_EN - adds mask[31:0]; a masked slot
//               presents zero mul/dt1/dt2 and forces pg_rst_III high.
// Revision    : 1.0 - initial release
// ============================================================================
module jt51_pg_sched
  import jt51_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [4:0]  wr_slot,
  input  logic [7:0]  wr_data,
`ifdef JT51_PG_SCHED_MASK_EN
  input  logic [31:0] mask,
`endif
  output logic [4:0]  slot,
  output logic [6:0]  kc,
  output logic [5:0]  kf,
  output logic [3:0]  mul,
  output logic [2:0]  dt1,
  output logic [1:0]  dt2,
  output logic        pg_rst_III,
  output logic        zero
);

  // Parameter storage
  logic [6:0]         r_kc_mem  [0:C_CHANS-1];
  logic [5:0]         r_kf_mem  [0:C_CHANS-1];
  logic [3:0]         r_mul_mem [0:C_SLOTS-1];
  logic [2:0]         r_dt1_mem [0:C_SLOTS-1];
  logic [1:0]         r_dt2_mem [0:C_SLOTS-1];
  logic [C_SLOTS-1:0] r_kon;
  logic [C_SLOTS-1:0] r_seen;

  // Presented outputs; r_slot doubles as the slot counter.
  logic [4:0] r_slot;
  logic [6:0] r_kc;
  logic [5:0] r_kf;
  logic [3:0] r_mul;
  logic [2:0] r_dt1;
  logic [1:0] r_dt2;
  logic       r_zero;
  logic       r_req;

  logic [4:0] w_nxt;
  logic       w_edge;
  logic       w_mask;

  // The slot being loaded on this cen edge is the one after the presented one.
  assign w_nxt  = r_slot + 5'd1;
  assign w_edge = r_kon[w_nxt] & ~r_seen[w_nxt];

`ifdef JT51_PG_SCHED_MASK_EN
  assign w_mask = mask[w_nxt];
`else
  assign w_mask = 1'b0;
`endif

  // Write port. Storage is read combinationally by the sequencer before these
  // non-blocking updates land, so a write to the slot being loaded on the same
  // edge shows up only on the next visit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_CHANS; i++) begin
        r_kc_mem[i] <= '0;
        r_kf_mem[i] <= '0;
      end
      for (int i = 0; i < C_SLOTS; i++) begin
        r_mul_mem[i] <= '0;
        r_dt1_mem[i] <= '0;
        r_dt2_mem[i] <= '0;
      end
      r_kon <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        SEL_KC:    r_kc_mem[wr_slot[2:0]] <= wr_data[6:0];
        SEL_KF:    r_kf_mem[wr_slot[2:0]] <= wr_data[7:2];
        SEL_DTMUL: begin
          r_dt1_mem[wr_slot] <= wr_data[6:4];
          r_mul_mem[wr_slot] <= wr_data[3:0];
        end
        SEL_DT2:   r_dt2_mem[wr_slot] <= wr_data[1:0];
        SEL_KON:   r_kon[wr_slot]     <= wr_data[0];
        default:   ;
      endcase
    end
  end

  // Sequencer: advances and loads the next slot's parameters on cen cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
      r_zero <= 1'b1;
      r_kc   <= '0;
      r_kf   <= '0;
      r_mul  <= '0;
      r_dt1  <= '0;
      r_dt2  <= '0;
      r_req  <= 1'b0;
      r_seen <= '0;
    end else if (cen) begin
      r_slot <= w_nxt;
      r_zero <= (w_nxt == 5'd0);
      r_kc   <= r_kc_mem[w_nxt[2:0]];
      r_kf   <= r_kf_mem[w_nxt[2:0]];
      r_mul  <= w_mask ? 4'd0 : r_mul_mem[w_nxt];
      r_dt1  <= w_mask ? 3'd0 : r_dt1_mem[w_nxt];
      r_dt2  <= w_mask ? 2'd0 : r_dt2_mem[w_nxt];
      // A masked slot injects a reset request into the same pipe so that
      // the forced reset lands on its stage III like a key-on reset would.
      r_req  <= w_edge | w_mask;
      // Edge memory tracks only what is seen at visits, so an off/on pair
      // between two visits is invisible.
      r_seen[w_nxt] <= r_kon[w_nxt];
    end
  end

  // r_req is aligned with the parameter outputs; the pipe adds two more cen
  // cycles to reach stage III.
  jt51_pg_sched_dly #(
    .DEPTH (C_PG_DLY)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .i_cen (cen),
    .i_d   (r_req),
    .o_q   (pg_rst_III)
  );

  assign slot = r_slot;
  assign zero = r_zero;
  assign kc   = r_kc;
  assign kf   = r_kf;
  assign mul  = r_mul;
  assign dt1  = r_dt1;
  assign dt2  = r_dt2;

endmodule
`default_nettype wire

// File: doc/jt51_pg_sched.md
JT51_PG_SCHED -- requirements
Module: jt51_pg_sched

Interface
REQ-001 clk  input  1  single system clock; all state on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 cen  input  1  clock enable; the slot sequence advances only on cycles with cen=1.
REQ-004 wr_en  input  1  parameter write strobe; honoured regardless of cen.
REQ-005 wr_sel  input  3  target field: 0=kc, 1=kf, 2={dt1,mul}, 3=dt2, 4=key-on; 5-7 ignored.
REQ-006 wr_slot  input  5  target slot; kc/kf use wr_slot[2:0] as channel.
REQ-007 wr_data  input  8  write data, LSB-aligned: kc[6:0], kf[7:2], {dt1[6:4],mul[3:0]}, dt2[1:0], kon[0].
REQ-008 slot  output  5  slot number whose parameters are presented this cycle.
REQ-009 kc, kf  output  7, 6  channel frequency for slot[2:0].
REQ-010 mul, dt1, dt2  output  4, 3, 2  operator parameters for slot.
REQ-011 pg_rst_III  output  1  phase reset, aligned to phase-generator stage III of the slot.
REQ-012 zero  output  1  high while slot==0.

Function
REQ-013 Slot counter: 5-bit, increments by 1 on each cen cycle, wraps 31->0.
REQ-014 Storage: 8 x {kc,kf} channel entries; 32 x {mul,dt1,dt2,kon,kon_seen} slot entries.
REQ-015 Outputs slot/kc/kf/mul/dt1/dt2/zero registered; updated only on cen cycles, holding otherwise.
REQ-016 Latency: a write accepted in cycle N is visible on outputs no earlier than the next visit of that slot after cycle N.
REQ-017 Write to the slot/channel being read in the same cen cycle: outputs show the old value; new value on the next visit.
REQ-018 Two writes to one field before its visit: last write wins.
REQ-019 Key-on edge: on visit, kon=1 and kon_seen=0 -> rst_req=1; kon_seen <= kon on every visit.
REQ-020 Key-off then key-on between two visits of a slot: no edge detected; no reset.
REQ-021 rst_req delayed through a 2-stage cen-gated pipe -> pg_rst_III, high exactly one cen cycle, two cen cycles after the slot's parameter outputs.
REQ-022 With cen=0 the delay pipe holds; pg_rst_III stays at its current value.
REQ-023 wr_sel 5-7 or wr_en=0: no storage change.

Reset
REQ-024 rst=1: counter=0, all storage=0, delay pipe=0; next cycle outputs slot=0, zero=1, all others 0.
REQ-025 rst mid-sequence: discards pending pg_rst pulses and pending edges; rst overrides a same-cycle write.

Configuration
REQ-026 JT51_PG_SCHED_MASK_EN defined: adds input mask[31:0]; slot with mask bit=1 outputs mul=dt1=dt2=0 and pg_rst_III forced high for its slot time; kon_seen still updates.
REQ-027 JT51_PG_SCHED_MASK_EN undefined: no mask port; behaviour per REQ-013..025.

Structure
REQ-028 Shared package jt51_pkg: wr_sel field codes, slot count (32), channel count (8), pipe depth (2).
REQ-029 One sub-module jt51_pg_sched_dly: cen-gated N-stage 1-bit delay with synchronous clear, used for pg_rst_III.

Verification
REQ-030 Reset then cen=1 constant -> slot sequence 0..31,0; zero high one cycle in 32; all params 0; pg_rst_III never high.
REQ-031 Write kc=0x4A, kf=0x80 (kf=32) to ch 3 -> slots 3,11,19,27 present kc=0x4A, kf=32; other slots 0.
REQ-032 Write kon=1 to slot 5 -> pg_rst_III high exactly 2 cen cycles after slot==5, once; next visit no pulse.
REQ-033 Write mul=7 to slot 9 in the cycle slot==9 is presented -> old value this visit, mul=7 32 cen cycles later.
REQ-034 cen toggling 1,0,0,1 during key-on pulse -> pulse stretched across held cycles, exactly one cen-qualified high cycle.
REQ-035 With JT51_PG_SCHED_MASK_EN, mask=0x00000001 -> slot 0 mul/dt1/dt2=0 and pg_rst_III high at slot 0's stage III every revolution.
